// File: rtl/serial_adder16.sv
// serial_adder16: bit-serial two's-complement adder, one bit per clock, valid/ready on both sides
module serial_adder16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, ps, ps_n;
    logic [CW-1:0]    cnt;
    logic             carry, h, s, c_n, last;

    // full adder built from two half-adder stages plus a carry OR
    assign h    = sa[0] ^ sb[0];
    assign s    = h ^ carry;
    assign c_n  = (sa[0] & sb[0]) | (h & carry);
    assign ps_n = {s, ps[WIDTH-1:1]};
    assign last = cnt == CW'(WIDTH - 1);

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (in_valid ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                :                 (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            ps       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            ps    <= ps_n;
            carry <= c_n;
            cnt   <= cnt + 1'b1;
            // on the MSB cycle carry still holds the carry into the MSB
            if (last) begin
                sum      <= ps_n;
                cout     <= c_n;
                overflow <= carry ^ c_n;
            end
        end
    end
endmodule
